// File: rtl/bary_pkg.sv
// Shared types and width helpers for the barycentric weight generator.
package bary_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StEdge,
    StSum,
    StDivU,
    StDivV,
    StDivW,
    StOut
  } bary_state_e;

  // Full-precision edge function width.
  function automatic int unsigned edge_w(input int unsigned coord_w);
    return 2 * coord_w + 3;
  endfunction

  // Sum of three edge values, with headroom for the winding negation.
  function automatic int unsigned sum_w(input int unsigned coord_w);
    return edge_w(coord_w) + 2;
  endfunction

  // Signed Q1.FRAC_W output weight.
  function automatic int unsigned out_w(input int unsigned frac_w);
    return frac_w + 2;
  endfunction

  // One quotient bit per cycle.
  function automatic int unsigned div_cyc(input int unsigned frac_w);
    return frac_w + 1;
  endfunction

  // Largest positive weight magnitude.
  function automatic int unsigned sat_mag(input int unsigned frac_w);
    return (32'd1 << (frac_w + 1)) - 32'd1;
  endfunction

endpackage

// File: rtl/bary_div_iter.sv
// Restoring unsigned divider, one quotient bit per cycle, fixed DIV_CYC cycles.
// The start cycle also retires the first quotient bit, so o_done is high in the
// cycle right after the last iteration edge. The caller guarantees the quotient
// fits in DIV_CYC bits; otherwise the result is meaningless.
module bary_div_iter
  import bary_pkg::*;
#(
  parameter int unsigned SUM_W  = 37,
  parameter int unsigned FRAC_W = 14
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_start,
  input  logic [SUM_W+FRAC_W-1:0] i_dividend,
  input  logic [SUM_W-1:0]        i_divisor,
  output logic                    o_busy,
  output logic                    o_done,
  output logic [FRAC_W:0]         o_quot
);

  localparam int unsigned DVD_W   = SUM_W + FRAC_W;
  localparam int unsigned DIV_CYC = div_cyc(FRAC_W);
  localparam int unsigned CNT_W   = $clog2(DIV_CYC + 1);

  logic [SUM_W-1:0]   r_rem;
  logic [SUM_W-1:0]   r_dvsr;
  logic [DIV_CYC-2:0] r_lo;
  logic [DIV_CYC-1:0] r_quot;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_busy;
  logic               r_done;

  logic [SUM_W-1:0]   w_rem_in;
  logic [SUM_W-1:0]   w_dvsr;
  logic               w_bit_in;
  logic [SUM_W:0]     w_trial;
  logic [SUM_W:0]     w_diff;
  logic               w_qbit;
  logic [SUM_W-1:0]   w_rem_nx;

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  always_comb begin
    w_rem_in = i_start ? {1'b0, i_dividend[DVD_W-1:DIV_CYC]} : r_rem;
    w_bit_in = i_start ? i_dividend[DIV_CYC-1] : r_lo[DIV_CYC-2];
    w_dvsr   = i_start ? i_divisor : r_dvsr;
    w_trial  = {w_rem_in, w_bit_in};
    w_diff   = w_trial - {1'b0, w_dvsr};
    w_qbit   = w_trial >= {1'b0, w_dvsr};
    w_rem_nx = w_qbit ? w_diff[SUM_W-1:0] : w_trial[SUM_W-1:0];
  end

  // Iteration state; start has priority and restarts from the new operands.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rem  <= '0;
      r_dvsr <= '0;
      r_lo   <= '0;
      r_quot <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (i_start) begin
        r_rem  <= w_rem_nx;
        r_dvsr <= i_divisor;
        r_lo   <= i_dividend[DIV_CYC-2:0];
        r_quot <= {{(DIV_CYC - 1){1'b0}}, w_qbit};
        r_cnt  <= CNT_W'(DIV_CYC - 1);
        r_busy <= 1'b1;
      end else if (r_busy) begin
        r_rem  <= w_rem_nx;
        r_lo   <= r_lo << 1;
        r_quot <= {r_quot[DIV_CYC-2:0], w_qbit};
        r_cnt  <= r_cnt - CNT_W'(1);
        if (r_cnt == CNT_W'(1)) begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end
      end
    end
  end

  assign o_busy = r_busy;
  assign o_done = r_done;
  assign o_quot = r_quot;

endmodule

// File: rtl/bary_coord_iter.sv
// Barycentric weight generator: edge functions, winding fix, then three
// sequential divisions on one shared iterative divider.
module bary_coord_iter
  import bary_pkg::*;
#(
  parameter int unsigned COORD_W = 16,
  parameter int unsigned FRAC_W  = 14
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_in_valid,
  output logic               o_in_ready,
  input  logic [COORD_W-1:0] i_v1_x,
  input  logic [COORD_W-1:0] i_v1_y,
  input  logic [COORD_W-1:0] i_v2_x,
  input  logic [COORD_W-1:0] i_v2_y,
  input  logic [COORD_W-1:0] i_v3_x,
  input  logic [COORD_W-1:0] i_v3_y,
  input  logic [COORD_W-1:0] i_p_x,
  input  logic [COORD_W-1:0] i_p_y,
  output logic               o_out_valid,
  input  logic               i_out_ready,
  output logic [FRAC_W+1:0]  o_b_u,
  output logic [FRAC_W+1:0]  o_b_v,
  output logic [FRAC_W+1:0]  o_b_w,
  output logic               o_inside,
  output logic               o_degenerate
);

  localparam int unsigned EDGE_W  = edge_w(COORD_W);
  localparam int unsigned SUM_W   = sum_w(COORD_W);
  localparam int unsigned OUT_W   = out_w(FRAC_W);
  localparam int unsigned DIV_CYC = div_cyc(FRAC_W);
  localparam int unsigned DIF_W   = COORD_W + 1;
  localparam int unsigned PROD_W  = 2 * DIF_W;
  localparam logic signed [OUT_W-1:0] SAT_POS = OUT_W'(sat_mag(FRAC_W));

  bary_state_e r_state, w_state_nx;

  logic signed [COORD_W-1:0] r_v1_x, r_v1_y, r_v2_x, r_v2_y, r_v3_x, r_v3_y, r_p_x, r_p_y;
  logic signed [PROD_W-1:0]  r_pu0, r_pu1, r_pv0, r_pv1, r_pw0, r_pw1;
  logic signed [EDGE_W-1:0]  w_e_u, w_e_v, w_e_w;
  logic signed [SUM_W-1:0]   w_sum, w_n_u, w_n_v, w_n_w, w_n_s;
  logic                      w_cw;
  logic signed [SUM_W-1:0]   r_w_u, r_w_v, r_w_w, r_s;
  logic                      r_inside, r_degen, r_kick;
  logic signed [OUT_W-1:0]   r_b_u, r_b_v, r_b_w;

  logic                      w_div_start, w_div_busy, w_div_done;
  logic [DIV_CYC-1:0]        w_div_quot;
  logic [SUM_W+FRAC_W-1:0]   w_div_dvd;
  logic signed [SUM_W-1:0]   w_op, w_cap;
  logic [SUM_W-1:0]          w_op_abs, w_cap_abs;
  logic                      w_sat;
  logic signed [OUT_W-1:0]   w_mag, w_res;

  // (b1 - a1) * (b2 - a2) at full precision.
  function automatic logic signed [PROD_W-1:0] dprod(input logic signed [COORD_W-1:0] b1,
                                                     input logic signed [COORD_W-1:0] a1,
                                                     input logic signed [COORD_W-1:0] b2,
                                                     input logic signed [COORD_W-1:0] a2);
    logic signed [DIF_W-1:0] d1, d2;
    d1 = DIF_W'(b1) - DIF_W'(a1);
    d2 = DIF_W'(b2) - DIF_W'(a2);
    return PROD_W'(d1) * PROD_W'(d2);
  endfunction

  // Capture the transaction on accept; later input changes are ignored.
  always_ff @(posedge clk) begin
    if (rst) begin
      {r_v1_x, r_v1_y, r_v2_x, r_v2_y, r_v3_x, r_v3_y, r_p_x, r_p_y} <= '0;
    end else if (i_in_valid && r_state == StIdle) begin
      r_v1_x <= i_v1_x;
      r_v1_y <= i_v1_y;
      r_v2_x <= i_v2_x;
      r_v2_y <= i_v2_y;
      r_v3_x <= i_v3_x;
      r_v3_y <= i_v3_y;
      r_p_x  <= i_p_x;
      r_p_y  <= i_p_y;
    end
  end

  // EDGE stage: register the six edge-function products.
  always_ff @(posedge clk) begin
    if (rst) begin
      {r_pu0, r_pu1, r_pv0, r_pv1, r_pw0, r_pw1} <= '0;
    end else if (r_state == StEdge) begin
      r_pu0 <= dprod(r_v3_x, r_v2_x, r_p_y, r_v2_y);
      r_pu1 <= dprod(r_v3_y, r_v2_y, r_p_x, r_v2_x);
      r_pv0 <= dprod(r_v1_x, r_v3_x, r_p_y, r_v3_y);
      r_pv1 <= dprod(r_v1_y, r_v3_y, r_p_x, r_v3_x);
      r_pw0 <= dprod(r_v2_x, r_v1_x, r_p_y, r_v1_y);
      r_pw1 <= dprod(r_v2_y, r_v1_y, r_p_x, r_v1_x);
    end
  end

  // Edge values, area sum and winding normalisation.
  always_comb begin
    w_e_u = EDGE_W'(r_pu0) - EDGE_W'(r_pu1);
    w_e_v = EDGE_W'(r_pv0) - EDGE_W'(r_pv1);
    w_e_w = EDGE_W'(r_pw0) - EDGE_W'(r_pw1);
    w_sum = SUM_W'(w_e_u) + SUM_W'(w_e_v) + SUM_W'(w_e_w);
    w_cw  = w_sum[SUM_W-1];
    w_n_u = w_cw ? -SUM_W'(w_e_u) : SUM_W'(w_e_u);
    w_n_v = w_cw ? -SUM_W'(w_e_v) : SUM_W'(w_e_v);
    w_n_w = w_cw ? -SUM_W'(w_e_w) : SUM_W'(w_e_w);
    w_n_s = w_cw ? -w_sum : w_sum;
  end

  // SUM stage: register normalised values and flags; r_kick launches division U.
  always_ff @(posedge clk) begin
    if (rst) begin
      {r_w_u, r_w_v, r_w_w, r_s} <= '0;
      r_inside <= 1'b0;
      r_degen  <= 1'b0;
      r_kick   <= 1'b0;
    end else begin
      r_kick <= (r_state == StSum);
      if (r_state == StSum) begin
        r_w_u    <= w_n_u;
        r_w_v    <= w_n_v;
        r_w_w    <= w_n_w;
        r_s      <= w_n_s;
        r_degen  <= (w_n_s == '0);
        r_inside <= (w_n_s != '0) && !w_n_u[SUM_W-1] && !w_n_v[SUM_W-1] && !w_n_w[SUM_W-1];
      end
    end
  end

  // Next division starts in the same cycle the previous one reports done.
  always_comb begin
    w_op        = r_kick ? r_w_u : ((r_state == StDivU) ? r_w_v : r_w_w);
    w_op_abs    = w_op[SUM_W-1] ? -w_op : w_op;
    w_div_dvd   = {w_op_abs, {FRAC_W{1'b0}}};
    w_div_start = !w_div_busy &&
                  (r_kick || (w_div_done && (r_state == StDivU || r_state == StDivV)));
    w_cap       = (r_state == StDivU) ? r_w_u : ((r_state == StDivV) ? r_w_v : r_w_w);
    w_cap_abs   = w_cap[SUM_W-1] ? -w_cap : w_cap;
    // Quotient would need more than DIV_CYC bits once |w| >= 2S.
    w_sat       = {1'b0, w_cap_abs} >= {r_s, 1'b0};
    w_mag       = w_sat ? SAT_POS : OUT_W'(w_div_quot);
    w_res       = r_degen ? '0 : (w_cap[SUM_W-1] ? -w_mag : w_mag);
  end

  bary_div_iter #(
    .SUM_W  (SUM_W),
    .FRAC_W (FRAC_W)
  ) u_div (
    .clk        (clk),
    .rst        (rst),
    .i_start    (w_div_start),
    .i_dividend (w_div_dvd),
    .i_divisor  (r_s),
    .o_busy     (w_div_busy),
    .o_done     (w_div_done),
    .o_quot     (w_div_quot)
  );

  // Store each signed, saturated weight as its division completes.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_b_u <= '0;
      r_b_v <= '0;
      r_b_w <= '0;
    end else if (w_div_done) begin
      case (r_state)
        StDivU:  r_b_u <= w_res;
        StDivV:  r_b_v <= w_res;
        StDivW:  r_b_w <= w_res;
        default: ;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= StIdle;
    else     r_state <= w_state_nx;
  end

  // Next-state sequencing.
  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      StIdle:  if (i_in_valid) w_state_nx = StEdge;
      StEdge:  w_state_nx = StSum;
      StSum:   w_state_nx = StDivU;
      StDivU:  if (w_div_done) w_state_nx = StDivV;
      StDivV:  if (w_div_done) w_state_nx = StDivW;
      StDivW:  if (w_div_done) w_state_nx = StOut;
      StOut:   if (i_out_ready) w_state_nx = StIdle;
      default: w_state_nx = StIdle;
    endcase
  end

  // Handshake and result outputs.
  always_comb begin
    o_in_ready   = (r_state == StIdle);
    o_out_valid  = (r_state == StOut);
    o_b_u        = r_b_u;
    o_b_v        = r_b_v;
    o_b_w        = r_b_w;
    o_inside     = r_inside;
    o_degenerate = r_degen;
  end

endmodule

// File: tb/tb_bary_coord_iter.sv
// Randomised self-checking bench for bary_coord_iter against an arithmetic model.
module tb_bary_coord_iter;

  localparam int COORD_W = 16;
  localparam int FRAC_W  = 14;
  localparam int OUT_W   = FRAC_W + 2;
  localparam int LAT     = 3 + 3 * (FRAC_W + 1);
  localparam longint SAT = (64'sd1 <<< (FRAC_W + 1)) - 1;

  logic               clk = 1'b0;
  logic               rst;
  logic               i_in_valid, o_in_ready, o_out_valid, i_out_ready;
  logic [COORD_W-1:0] i_v1_x, i_v1_y, i_v2_x, i_v2_y, i_v3_x, i_v3_y, i_p_x, i_p_y;
  logic [OUT_W-1:0]   o_b_u, o_b_v, o_b_w;
  logic               o_inside, o_degenerate;

  int n_total = 0;
  int n_bad   = 0;

  // v1x v1y v2x v2y v3x v3y px py
  longint t_c[8];
  longint exp_b[3];
  longint exp_in, exp_dg;

  bary_coord_iter #(
    .COORD_W (COORD_W),
    .FRAC_W  (FRAC_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .i_in_valid   (i_in_valid),
    .o_in_ready   (o_in_ready),
    .i_v1_x       (i_v1_x),
    .i_v1_y       (i_v1_y),
    .i_v2_x       (i_v2_x),
    .i_v2_y       (i_v2_y),
    .i_v3_x       (i_v3_x),
    .i_v3_y       (i_v3_y),
    .i_p_x        (i_p_x),
    .i_p_y        (i_p_y),
    .o_out_valid  (o_out_valid),
    .i_out_ready  (i_out_ready),
    .o_b_u        (o_b_u),
    .o_b_v        (o_b_v),
    .o_b_w        (o_b_w),
    .o_inside     (o_inside),
    .o_degenerate (o_degenerate)
  );

  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input longint got, input longint exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic longint edge_fn(input longint ax, input longint ay, input longint bx,
                                     input longint by, input longint px, input longint py);
    return (bx - ax) * (py - ay) - (by - ay) * (px - ax);
  endfunction

  // Reference: plain integer arithmetic on the captured transaction.
  task automatic compute_ref();
    longint w[3];
    longint s, a, mag;
    w[0] = edge_fn(t_c[2], t_c[3], t_c[4], t_c[5], t_c[6], t_c[7]);
    w[1] = edge_fn(t_c[4], t_c[5], t_c[0], t_c[1], t_c[6], t_c[7]);
    w[2] = edge_fn(t_c[0], t_c[1], t_c[2], t_c[3], t_c[6], t_c[7]);
    s = w[0] + w[1] + w[2];
    if (s < 0) begin
      s = -s;
      for (int i = 0; i < 3; i++) w[i] = -w[i];
    end
    exp_dg = (s == 0) ? 1 : 0;
    for (int i = 0; i < 3; i++) begin
      if (s == 0) begin
        exp_b[i] = 0;
      end else begin
        a   = (w[i] < 0) ? -w[i] : w[i];
        mag = (a >= 2 * s) ? SAT : (a * (64'sd1 <<< FRAC_W)) / s;
        exp_b[i] = (w[i] < 0) ? -mag : mag;
      end
    end
    exp_in = (s != 0 && w[0] >= 0 && w[1] >= 0 && w[2] >= 0) ? 1 : 0;
  endtask

  task automatic set_pts(input longint a0, input longint a1, input longint a2, input longint a3,
                         input longint a4, input longint a5, input longint a6, input longint a7);
    t_c[0] = a0; t_c[1] = a1; t_c[2] = a2; t_c[3] = a3;
    t_c[4] = a4; t_c[5] = a5; t_c[6] = a6; t_c[7] = a7;
  endtask

  // Wait for ready, present the transaction for one accept edge, then scramble inputs.
  task automatic drive_accept(input string tag);
    int n;
    n = 0;
    while (!o_in_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk_eq({tag, ".ready"}, longint'(o_in_ready), 1);
    i_v1_x = COORD_W'(t_c[0]); i_v1_y = COORD_W'(t_c[1]);
    i_v2_x = COORD_W'(t_c[2]); i_v2_y = COORD_W'(t_c[3]);
    i_v3_x = COORD_W'(t_c[4]); i_v3_y = COORD_W'(t_c[5]);
    i_p_x  = COORD_W'(t_c[6]); i_p_y  = COORD_W'(t_c[7]);
    i_in_valid = 1'b1;
    @(posedge clk); #1;
    i_in_valid = 1'b0;
    i_v1_x = COORD_W'($urandom); i_v1_y = COORD_W'($urandom);
    i_v2_x = COORD_W'($urandom); i_v2_y = COORD_W'($urandom);
    i_v3_x = COORD_W'($urandom); i_v3_y = COORD_W'($urandom);
    i_p_x  = COORD_W'($urandom); i_p_y  = COORD_W'($urandom);
  endtask

  task automatic chk_result(input string tag);
    chk_eq({tag, ".b_u"}, longint'($signed(o_b_u)), exp_b[0]);
    chk_eq({tag, ".b_v"}, longint'($signed(o_b_v)), exp_b[1]);
    chk_eq({tag, ".b_w"}, longint'($signed(o_b_w)), exp_b[2]);
    chk_eq({tag, ".inside"}, longint'(o_inside), exp_in);
    chk_eq({tag, ".degen"}, longint'(o_degenerate), exp_dg);
  endtask

  task automatic run_txn(input string tag, input int hold);
    int lat;
    compute_ref();
    drive_accept(tag);
    lat = 0;
    while (!o_out_valid && lat < 200) begin
      if (lat == 5) chk_eq({tag, ".busy_ready"}, longint'(o_in_ready), 0);
      @(posedge clk); #1;
      lat++;
    end
    chk_eq({tag, ".latency"}, lat, LAT);
    chk_result(tag);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk_eq({tag, ".hold_valid"}, longint'(o_out_valid), 1);
      chk_eq({tag, ".hold_ready"}, longint'(o_in_ready), 0);
      chk_result({tag, ".hold"});
    end
    i_out_ready = 1'b1;
    @(posedge clk); #1;
    i_out_ready = 1'b0;
    chk_eq({tag, ".post_valid"}, longint'(o_out_valid), 0);
    chk_eq({tag, ".post_ready"}, longint'(o_in_ready), 1);
  endtask

  function automatic longint rnd_small();
    return longint'($urandom_range(0, 127)) - 64;
  endfunction

  function automatic longint rnd_full();
    logic signed [COORD_W-1:0] v;
    v = COORD_W'($urandom);
    return longint'(v);
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int     seen;
    int     mode;
    longint dx, dy, k;
    rst = 1'b1;
    i_in_valid = 1'b0;
    i_out_ready = 1'b0;
    {i_v1_x, i_v1_y, i_v2_x, i_v2_y, i_v3_x, i_v3_y, i_p_x, i_p_y} = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_eq("reset.in_ready", longint'(o_in_ready), 1);
    chk_eq("reset.out_valid", longint'(o_out_valid), 0);
    chk_eq("reset.b_u", longint'(o_b_u), 0);
    chk_eq("reset.b_v", longint'(o_b_v), 0);
    chk_eq("reset.b_w", longint'(o_b_w), 0);
    chk_eq("reset.inside", longint'(o_inside), 0);
    chk_eq("reset.degen", longint'(o_degenerate), 0);
    rst = 1'b0;
    @(posedge clk); #1;

    set_pts(0, 0, 8, 0, 0, 8, 2, 2);   run_txn("ccw", 0);
    set_pts(0, 0, 0, 8, 8, 0, 2, 2);   run_txn("cw", 0);
    set_pts(0, 0, 8, 0, 0, 8, 10, 0);  run_txn("out10", 0);
    set_pts(0, 0, 8, 0, 0, 8, 20, 0);  run_txn("out20", 0);
    set_pts(0, 0, 4, 4, 8, 8, 3, -5);  run_txn("degen", 0);
    set_pts(0, 0, 8, 0, 0, 8, 2, 2);   run_txn("bp", 10);

    // Reset while the second division is running.
    set_pts(0, 0, 8, 0, 0, 8, 3, 1);
    drive_accept("rstmid");
    repeat (25) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk_eq("rstmid.out_valid", longint'(o_out_valid), 0);
    chk_eq("rstmid.in_ready", longint'(o_in_ready), 1);
    chk_eq("rstmid.b_u", longint'(o_b_u), 0);
    seen = 0;
    repeat (60) begin
      @(posedge clk); #1;
      if (o_out_valid) seen++;
    end
    chk_eq("rstmid.quiet", seen, 0);
    set_pts(-3, 1, 9, -2, 2, 11, 2, 3); run_txn("after_rst", 0);

    for (int n = 0; n < 30; n++) begin
      mode = $urandom_range(0, 3);
      case (mode)
        0: for (int i = 0; i < 8; i++) t_c[i] = rnd_small();
        1: for (int i = 0; i < 8; i++) t_c[i] = rnd_full();
        2: begin
          t_c[0] = rnd_small(); t_c[1] = rnd_small();
          dx = longint'($urandom_range(0, 15)) - 8;
          dy = longint'($urandom_range(0, 15)) - 8;
          k  = longint'($urandom_range(0, 8)) - 4;
          t_c[2] = t_c[0] + dx;     t_c[3] = t_c[1] + dy;
          t_c[4] = t_c[0] + k * dx; t_c[5] = t_c[1] + k * dy;
          t_c[6] = rnd_small();     t_c[7] = rnd_small();
        end
        default: begin
          set_pts(-40, -30, 50, -20, 0, 60, 0, 0);
          t_c[6] = longint'($urandom_range(0, 99)) - 50;
          t_c[7] = longint'($urandom_range(0, 99)) - 40;
        end
      endcase
      run_txn($sformatf("rnd%0d", n), $urandom_range(0, 3));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
